// File: rtl/rom_dump_uart_tx_if.sv
// Bus between the ROM reader side and the hex-record UART transmitter.
// Latency: none, this is wiring only.
// Backpressure: none; requests arriving while busy is high are dropped by the transmitter.
interface rom_dump_uart_tx_if #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDRESS_WIDTH = 9
);
    logic [ADDRESS_WIDTH-1:0] address_line;
    logic [DATA_WIDTH-1:0]    data_line;
    logic                     send;
    logic                     auto_on_change;
    logic                     tx;
    logic                     busy;
    logic                     done;

    // Reader / host side: supplies the address/data pair and the requests.
    modport master (
        output address_line,
        output data_line,
        output send,
        output auto_on_change,
        input  tx,
        input  busy,
        input  done
    );

    // Transmitter side.
    modport slave (
        input  address_line,
        input  data_line,
        input  send,
        input  auto_on_change,
        output tx,
        output busy,
        output done
    );
endinterface

// File: rtl/rom_dump_uart_tx.sv
// Snapshots address/data and sends it as an "AAA:DD\r\n" ASCII record on an 8N1 UART line.
// Latency: start bit on tx one cycle after the trigger edge; record lasts chars*10*CLK_DIV cycles.
// Backpressure: none; send/address changes while busy are ignored, nothing is queued.
module rom_dump_uart_tx #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDRESS_WIDTH = 9,
    parameter int CLK_DIV       = 434
) (
    input  logic              clk,
    input  logic              reset_n,
    rom_dump_uart_tx_if.slave bus
);

    // Record geometry: hex digits per field, padded to whole nibbles.
    localparam int ADDR_DIGITS = (ADDRESS_WIDTH + 3) / 4;
    localparam int DATA_DIGITS = (DATA_WIDTH + 3) / 4;
    localparam int ADDR_PAD_W  = ADDR_DIGITS * 4;
    localparam int DATA_PAD_W  = DATA_DIGITS * 4;
    // address digits + ':' + data digits + CR + LF
    localparam int REC_LEN     = ADDR_DIGITS + DATA_DIGITS + 3;
    localparam int IDX_W       = $clog2(REC_LEN);
    localparam int TMR_W       = $clog2(CLK_DIV);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(REC_LEN - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(CLK_DIV - 1);
    localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t                   state;
    state_t                   state_nxt;
    logic [TMR_W-1:0]         bit_timer;
    logic [2:0]               bit_cnt;
    logic [IDX_W-1:0]         char_idx;
    logic [ADDR_PAD_W-1:0]    addr_snap;
    logic [DATA_PAD_W-1:0]    data_snap;
    logic [ADDRESS_WIDTH-1:0] addr_prev;
    logic                     trig;
    logic                     bit_end;
    logic                     last_char;
    logic [7:0]               cur_char;
    logic                     tx_int;
    logic                     busy_int;
    logic                     done_q;

    // Nibble to uppercase ASCII hex digit.
    function automatic logic [7:0] to_hex(input logic [3:0] n);
        if (n > 4'd9) begin
            to_hex = 8'h37 + {4'h0, n};
        end else begin
            to_hex = 8'h30 + {4'h0, n};
        end
    endfunction

    // A simultaneous send and address change collapse into one trigger.
    assign trig      = bus.send | (bus.auto_on_change & (bus.address_line != addr_prev));
    assign bit_end   = (bit_timer == TMR_LAST);
    assign last_char = (char_idx == LAST_IDX);

    // State register; async reset drops tx back to idle-high at once.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: start bit, 8 data bits, stop bit, then next char or idle.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (trig) state_nxt = S_START;
            S_START: if (bit_end) state_nxt = S_DATA;
            S_DATA:  if (bit_end && (bit_cnt == 3'd7)) state_nxt = S_STOP;
            S_STOP: begin
                if (bit_end) begin
                    state_nxt = last_char ? S_IDLE : S_START;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Line level and busy decoded straight from the state.
    always_comb begin
        tx_int   = 1'b1;
        busy_int = 1'b1;
        case (state)
            S_IDLE:  busy_int = 1'b0;
            S_START: tx_int   = 1'b0;
            S_DATA:  tx_int   = cur_char[bit_cnt];
            default: tx_int   = 1'b1;
        endcase
    end

    // Character currently on the wire, picked from the snapshot by position.
    always_comb begin
        int                    idx;
        logic [ADDR_PAD_W-1:0] addr_sh;
        logic [DATA_PAD_W-1:0] data_sh;
        idx      = int'(char_idx);
        addr_sh  = '0;
        data_sh  = '0;
        cur_char = 8'h0A;
        if (idx < ADDR_DIGITS) begin
            addr_sh  = addr_snap >> (4 * (ADDR_DIGITS - 1 - idx));
            cur_char = to_hex(addr_sh[3:0]);
        end else if (idx == ADDR_DIGITS) begin
            cur_char = 8'h3A;
        end else if (idx < ADDR_DIGITS + 1 + DATA_DIGITS) begin
            data_sh  = data_snap >> (4 * (ADDR_DIGITS + DATA_DIGITS - idx));
            cur_char = to_hex(data_sh[3:0]);
        end else if (idx == REC_LEN - 2) begin
            cur_char = 8'h0D;
        end else begin
            cur_char = 8'h0A;
        end
    end

    // Bit timing, character sequencing, snapshot and change tracking.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bit_timer <= '0;
            bit_cnt   <= '0;
            char_idx  <= '0;
            addr_snap <= '0;
            data_snap <= '0;
            addr_prev <= '0;
            done_q    <= 1'b0;
        end else begin
            // Tracks every cycle so changes seen while busy are absorbed.
            addr_prev <= bus.address_line;
            done_q    <= 1'b0;
            if (state == S_IDLE) begin
                if (trig) begin
                    addr_snap <= ADDR_PAD_W'(bus.address_line);
                    data_snap <= DATA_PAD_W'(bus.data_line);
                    char_idx  <= '0;
                    bit_timer <= '0;
                    bit_cnt   <= '0;
                end
            end else begin
                bit_timer <= bit_end ? '0 : (bit_timer + TMR_ONE);
                if ((state == S_DATA) && bit_end) begin
                    bit_cnt <= bit_cnt + 3'd1;
                end
                if ((state == S_STOP) && bit_end) begin
                    if (last_char) begin
                        done_q <= 1'b1;
                    end else begin
                        char_idx <= char_idx + IDX_ONE;
                    end
                end
            end
        end
    end

    assign bus.tx   = tx_int;
    assign bus.busy = busy_int;
    assign bus.done = done_q;

endmodule
